stream_downsizer: RTL
=====================

// Module: stream_downsizer
// PURPOSE
//  Consumes the packed byte stream produced by stream_normalizer (IN_BYTES-wide beats, valid bytes
//  in low lanes, only the final beat of a packet partial) and re-emits it as narrower OUT_BYTES-wide
//  beats with the same cnt/last encoding. Sits directly downstream of stream_normalizer, feeding
//  narrow sinks (serial MACs, byte-wide FIFOs). One beat of buffering, full output throughput.
// PARAMETERS
//  IN_BYTES   8  bytes per input beat; power of 2, >= 2
//  OUT_BYTES  2  bytes per output beat; power of 2, >= 2, IN_BYTES % OUT_BYTES == 0, OUT_BYTES < IN_BYTES
// PORTS
//  clk        in   1                    rising-edge clock
//  rst_n      in   1                    reset; one clock; asynchronous, active-low
//  in_data    in   IN_BYTES*8           input bytes; byte 0 = bits [7:0], sent first
//  in_cnt     in   $clog2(IN_BYTES)     valid bytes in beat; 0 encodes IN_BYTES (full)
//  in_last    in   1                    final beat of packet
//  in_valid   in   1                    input handshake valid
//  in_ready   out  1                    input handshake ready
//  out_data   out  OUT_BYTES*8          output bytes, same lane order
//  out_cnt    out  $clog2(OUT_BYTES)    valid bytes in out beat; 0 encodes OUT_BYTES
//  out_last   out  1                    final out beat of packet
//  out_valid  out  1                    output handshake valid
//  out_ready  in   1                    output handshake ready
// BEHAVIOUR
//  - Reset (async, rst_n=0): hold register and chunk index cleared; out_valid=0, out_data=0,
//    out_cnt=0, out_last=0, state EMPTY. in_ready=1 in the first cycle after release.
//  - Transfer occurs on rising clk when valid && ready; no combinational valid->ready dependency
//    on either side except in_ready depending on out_ready (below).
//  - States: EMPTY (no held beat) / SEND (held beat, chunk idx k). EMPTY --in xfer--> SEND k=0.
//    SEND: out xfer on non-final chunk -> k+1; out xfer on final chunk -> SEND k=0 if in xfer
//    same cycle, else EMPTY.
//  - Capture: bytes B = (in_cnt==0) ? IN_BYTES : in_cnt; lanes >= B zeroed in hold register;
//    N = ceil(B/OUT_BYTES) chunks (1..IN_BYTES/OUT_BYTES); hold_last = in_last.
//  - Output (registered from hold state): out_valid = (state==SEND); out_data = hold[k*OUT_BYTES*8 +:
//    OUT_BYTES*8]; final chunk k==N-1: out_cnt = (B % OUT_BYTES) (0 = full), out_last = hold_last;
//    non-final chunks: out_cnt=0, out_last=0.
//  - in_ready = (state==EMPTY) || (k==N-1 && out_ready). Enables back-to-back beats with no bubble.
//  - Latency: input accepted at edge N -> first chunk valid after edge N (visible cycle N+1).
//  - Throughput: one out beat per cycle while out_ready=1; a full in beat takes IN_BYTES/OUT_BYTES
//    cycles.
//  - out_data/out_cnt/out_last stable while out_valid && !out_ready; never retracted.
//  - in_cnt non-zero on non-last beats is passed through unchanged (no repacking; that is upstream's
//    job); downstream sees a partial non-last out beat.
//  - Reset mid-beat: held data discarded, out_valid falls immediately (async), no partial resume.
// TESTING  (IN_BYTES=8, OUT_BYTES=2)
//  1 reset 2 cycles, release -> out_valid=0, in_ready=1, out_data=0, out_cnt=0, out_last=0.
//  2 in 0x0807060504030201 cnt=0 last=0, out_ready=1 -> out 0x0201,0x0403,0x0605,0x0807 on 4
//    consecutive cycles, cnt=0, last=0; in_ready=0 during first 3 chunks, 1 during 4th.
//  3 in 0x0000000000302010 cnt=3 last=1 -> out 0x2010 cnt=0 last=0, then 0x0030 cnt=1 last=1; EMPTY.
//  4 as 2 with out_ready toggling 1,0,1,0... -> each chunk held stable while stalled, 4 chunks
//    exactly once, in order.
//  5 two full beats back-to-back (in_valid held), out_ready=1 -> 8 out beats in 8 consecutive cycles,
//    no bubble; second beat's last propagates on its 4th chunk only.
//  6 rst_n=0 after 2 chunks of a full beat -> out_valid=0 same cycle; after release in_ready=1 and the
//    next beat starts at chunk 0 (0x0201-style lane 0 first).

Source files
------------

// File: rtl/stream_downsizer.sv
// stream_downsizer: splits packed IN_BYTES-wide beats into OUT_BYTES-wide beats.
// The cnt/last encoding is preserved. One beat of buffering and full output throughput.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   in_data/cnt/last    input beat; in_cnt == 0 means a full beat
//   in_valid/in_ready   input handshake (in_ready depends on out_ready)
//   out_data/cnt/last   output beat; out_cnt == 0 means a full beat
//   out_valid/out_ready output handshake
module stream_downsizer #(
  parameter int unsigned IN_BYTES  = 8,
  parameter int unsigned OUT_BYTES = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [IN_BYTES*8-1:0]         in_data,
  input  logic [$clog2(IN_BYTES)-1:0]   in_cnt,
  input  logic                          in_last,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [OUT_BYTES*8-1:0]        out_data,
  output logic [$clog2(OUT_BYTES)-1:0]  out_cnt,
  output logic                          out_last,
  output logic                          out_valid,
  input  logic                          out_ready
);

  localparam int unsigned InW     = $clog2(IN_BYTES);
  localparam int unsigned OutW    = $clog2(OUT_BYTES);
  localparam int unsigned Ratio   = IN_BYTES / OUT_BYTES;
  localparam int unsigned KW      = $clog2(Ratio);
  localparam int unsigned OutBits = OUT_BYTES * 8;

  typedef enum logic [0:0] {StEmpty, StSend} state_e;

  state_e                state_q, state_d;
  logic [IN_BYTES*8-1:0] hold_q, hold_d;
  logic [KW-1:0]         k_q, k_d;
  logic [KW-1:0]         last_idx_q, last_idx_d;
  logic [OutW-1:0]       tail_cnt_q, tail_cnt_d;
  logic                  hold_last_q, hold_last_d;

  logic [InW:0]          cap_bytes;
  logic [InW:0]          cap_chunks;
  logic [KW-1:0]         cap_last_idx;
  logic [IN_BYTES*8-1:0] cap_data;
  logic                  is_final;
  logic                  in_xfer;
  logic                  out_xfer;

  // Capture path: byte count, chunk count and lane masking of the incoming beat.
  always_comb begin
    cap_bytes    = (in_cnt == '0) ? (InW+1)'(IN_BYTES) : {1'b0, in_cnt};
    cap_chunks   = (cap_bytes + (InW+1)'(OUT_BYTES - 1)) >> OutW;
    cap_last_idx = KW'(cap_chunks - (InW+1)'(1));
    cap_data     = '0;
    for (int i = 0; i < int'(IN_BYTES); i++) begin
      // Lanes beyond the valid count are zeroed so partial chunks carry no stale bytes.
      cap_data[i*8 +: 8] = (i < int'(cap_bytes)) ? in_data[i*8 +: 8] : 8'h00;
    end
  end

  // Outputs come straight from the hold state; nothing combinational from in_valid.
  always_comb begin
    is_final  = (k_q == last_idx_q);
    out_valid = (state_q == StSend);
    out_data  = out_valid ? hold_q[int'(k_q)*OutBits +: OutBits] : '0;
    out_cnt   = (out_valid && is_final) ? tail_cnt_q : '0;
    out_last  = out_valid && is_final && hold_last_q;
    // Accept the next beat while the final chunk leaves, so beats run back-to-back.
    in_ready  = (state_q == StEmpty) || (is_final && out_ready);
    in_xfer   = in_valid && in_ready;
    out_xfer  = out_valid && out_ready;
  end

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    k_d         = k_q;
    last_idx_d  = last_idx_q;
    tail_cnt_d  = tail_cnt_q;
    hold_last_d = hold_last_q;
    case (state_q)
      StEmpty: begin
        if (in_xfer) begin
          state_d     = StSend;
          hold_d      = cap_data;
          k_d         = '0;
          last_idx_d  = cap_last_idx;
          tail_cnt_d  = in_cnt[OutW-1:0];
          hold_last_d = in_last;
        end
      end
      StSend: begin
        if (out_xfer) begin
          if (!is_final) begin
            k_d = k_q + KW'(1);
          end else if (in_xfer) begin
            hold_d      = cap_data;
            k_d         = '0;
            last_idx_d  = cap_last_idx;
            tail_cnt_d  = in_cnt[OutW-1:0];
            hold_last_d = in_last;
          end else begin
            state_d = StEmpty;
          end
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StEmpty;
      hold_q      <= '0;
      k_q         <= '0;
      last_idx_q  <= '0;
      tail_cnt_q  <= '0;
      hold_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      k_q         <= k_d;
      last_idx_q  <= last_idx_d;
      tail_cnt_q  <= tail_cnt_d;
      hold_last_q <= hold_last_d;
    end
  end

endmodule
